// File: rtl/dds_spi_pkg.sv
// Shared types and helpers for the AD9952 command sequencer.
// Register map lengths and instruction-byte encoding live here.
package dds_spi_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SEND,
        ST_DRAIN,
        ST_RESP
    } state_e;

    localparam logic [4:0] ADDR_CFR1 = 5'h00;
    localparam logic [4:0] ADDR_CFR2 = 5'h01;
    localparam logic [4:0] ADDR_ASF  = 5'h02;
    localparam logic [4:0] ADDR_ARR  = 5'h03;
    localparam logic [4:0] ADDR_FTW0 = 5'h04;
    localparam logic [4:0] ADDR_POW0 = 5'h05;

    // Returns {valid, byte_count}; unsupported addresses yield valid = 0.
    function automatic logic [3:0] reg_len(input logic [4:0] addr);
        logic [3:0] len;
        case (addr)
            ADDR_CFR1: len = {1'b1, 3'd4};
            ADDR_CFR2: len = {1'b1, 3'd3};
            ADDR_ASF:  len = {1'b1, 3'd2};
            ADDR_ARR:  len = {1'b1, 3'd1};
            ADDR_FTW0: len = {1'b1, 3'd4};
            ADDR_POW0: len = {1'b1, 3'd2};
            default:   len = {1'b0, 3'd0};
        endcase
        return len;
    endfunction

    function automatic logic [7:0] instr_byte(input logic rw, input logic [4:0] addr);
        return {rw, 2'b00, addr};
    endfunction

endpackage

// File: rtl/dds_spi_sequencer.sv
// Command sequencer in front of spi_master_9952: turns register read/write
// commands into an instruction byte plus data bytes and collects read-back data.
module dds_spi_sequencer
    import dds_spi_pkg::*;
#(
    parameter bit          INIT_EN   = 1'b1,
    parameter logic [31:0] INIT_CFR1 = 32'h0000_0000,
    parameter logic [23:0] INIT_CFR2 = 24'h00_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [4:0]  cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        have_data,
    output logic [7:0]  data_o,
    input  logic        rdreq,
    input  logic        spi_busy,
    input  logic [7:0]  miso_byte,
    input  logic        wrreq,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        init_done,
    output logic        err_addr
);

    state_e      state_q, state_d;
    logic [1:0]  init_step_q, init_step_d;
    logic        init_done_q, init_done_d;
    logic        rw_q, rw_d;
    logic [2:0]  len_q, len_d;
    logic [2:0]  left_q, left_d;
    logic [31:0] shift_q, shift_d;
    logic        have_data_q, have_data_d;
    logic [7:0]  data_o_q, data_o_d;
    logic        rx_first_q, rx_first_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        err_addr_q, err_addr_d;

    logic [3:0]  cmd_len;
    logic        load;
    logic        ld_rw;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic [2:0]  ld_len;
    logic [2:0]  pad;

    assign cmd_len   = reg_len(cmd_addr);
    assign cmd_ready = (state_q == ST_IDLE) && init_done_q && !spi_busy;

    always_comb begin
        state_d     = state_q;
        init_step_d = init_step_q;
        init_done_d = init_done_q;
        rw_d        = rw_q;
        len_d       = len_q;
        left_d      = left_q;
        shift_d     = shift_q;
        have_data_d = have_data_q;
        data_o_d    = data_o_q;
        rx_first_d  = rx_first_q;
        rx_cnt_d    = rx_cnt_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        err_addr_d  = 1'b0;
        load        = 1'b0;
        ld_rw       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        ld_len      = '0;
        pad         = '0;

        case (state_q)
            ST_INIT: begin
                if (!spi_busy) begin
                    case (init_step_q)
                        2'd0: begin
                            load        = 1'b1;
                            ld_addr     = ADDR_CFR1;
                            ld_data     = INIT_CFR1;
                            ld_len      = 3'd4;
                            init_step_d = 2'd1;
                        end
                        2'd1: begin
                            load        = 1'b1;
                            ld_addr     = ADDR_CFR2;
                            ld_data     = {8'h00, INIT_CFR2};
                            ld_len      = 3'd3;
                            init_step_d = 2'd2;
                        end
                        default: begin
                            init_done_d = 1'b1;
                            state_d     = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_len[3]) begin
                        load    = 1'b1;
                        ld_rw   = cmd_rw;
                        ld_addr = cmd_addr;
                        ld_data = cmd_data;
                        ld_len  = cmd_len[2:0];
                    end else begin
                        err_addr_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (rdreq) begin
                    if (left_q == 3'd0) begin
                        have_data_d = 1'b0;
                        state_d     = ST_DRAIN;
                    end else begin
                        data_o_d = shift_q[31:24];
                        shift_d  = shift_q << 8;
                        left_d   = left_q - 3'd1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!spi_busy && (!rw_q || rx_cnt_q == len_q)) begin
                    if (rw_q) begin
                        state_d    = ST_RESP;
                        rd_valid_d = 1'b1;
                    end else begin
                        state_d = init_done_q ? ST_IDLE : ST_INIT;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // First wrreq of a frame belongs to the instruction slot and is dropped.
        if ((state_q == ST_SEND || state_q == ST_DRAIN) && wrreq && rw_q) begin
            if (!rx_first_q) begin
                rx_first_d = 1'b1;
            end else if (rx_cnt_q != len_q) begin
                rd_data_d = {rd_data_q[23:0], miso_byte};
                rx_cnt_d  = rx_cnt_q + 3'd1;
            end
        end

        // Write data is left-aligned so each byte pops from the top of shift_q.
        if (load) begin
            pad         = 3'd4 - ld_len;
            rw_d        = ld_rw;
            len_d       = ld_len;
            left_d      = ld_len;
            shift_d     = ld_rw ? '0 : (ld_data << {pad, 3'b000});
            data_o_d    = instr_byte(ld_rw, ld_addr);
            have_data_d = 1'b1;
            rx_first_d  = 1'b0;
            rx_cnt_d    = '0;
            state_d     = ST_SEND;
            if (ld_rw) begin
                rd_data_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT_EN ? ST_INIT : ST_IDLE;
            init_step_q <= '0;
            init_done_q <= !INIT_EN;
            rw_q        <= 1'b0;
            len_q       <= '0;
            left_q      <= '0;
            shift_q     <= '0;
            have_data_q <= 1'b0;
            data_o_q    <= '0;
            rx_first_q  <= 1'b0;
            rx_cnt_q    <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            err_addr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_step_q <= init_step_d;
            init_done_q <= init_done_d;
            rw_q        <= rw_d;
            len_q       <= len_d;
            left_q      <= left_d;
            shift_q     <= shift_d;
            have_data_q <= have_data_d;
            data_o_q    <= data_o_d;
            rx_first_q  <= rx_first_d;
            rx_cnt_q    <= rx_cnt_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign have_data = have_data_q;
    assign data_o    = data_o_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign init_done = init_done_q;
    assign err_addr  = err_addr_q;

endmodule
